// File: rtl/ffsr_pulse_pkg.sv
// Shared types and helpers for the ffsr_pulse scheduler: FSM state encoding
// and the binary-to-thermometer conversion used for reg_init and shadow checks.
package ffsr_pulse_pkg;

  localparam int THERM_MAX = 64;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_STEP,
    S_LOAD,
    S_ACK
  } state_t;

  // Value v sets the v least-significant bits; callers truncate to their width,
  // which on a [0:N-1] vector places the ones at indices N-v..N-1.
  function automatic logic [THERM_MAX-1:0] therm(input int value);
    logic [THERM_MAX-1:0] t;
    for (int i = 0; i < THERM_MAX; i++) begin
      t[i] = (i < value);
    end
    return t;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the first asserted request at or after ptr wins.
// Purely combinational; gnt is one-hot, any flags a valid winner.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               any
);

  logic [NUM_REQ-1:0] req_rot;
  logic [ID_W:0]      sum;

  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    any     = 1'b0;
    sum     = '0;
    // Rotate so bit 0 is the requester ptr points at.
    req_rot = NUM_REQ'({req, req} >> ptr);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any && req_rot[k]) begin
        any = 1'b1;
        sum = {1'b0, ptr} + (ID_W+1)'(k);
        if (sum >= (ID_W+1)'(NUM_REQ)) begin
          sum = sum - (ID_W+1)'(NUM_REQ);
        end
        gnt_id = sum[ID_W-1:0];
      end
    end
    if (any) begin
      gnt = NUM_REQ'(1) << gnt_id;
    end
  end

endmodule

// File: rtl/ffsr_pulse_sched.sv
// Shares one thermometer register among NUM_REQ requesters, stepping or
// jumping it to each granted target and shadowing its level in binary.
module ffsr_pulse_sched
  import ffsr_pulse_pkg::*;
#(
  parameter int INPUT_SIZE = 8,
  parameter int NUM_REQ    = 4,
  parameter int CNT_W      = $clog2(INPUT_SIZE + 1),
  parameter int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] req_target,
  input  logic [NUM_REQ-1:0]       req_load,
  input  logic [0:INPUT_SIZE-1]    reg_out,
  output logic                     reg_rst,
  output logic                     reg_inc,
  output logic                     reg_dec,
  output logic [0:INPUT_SIZE-1]    reg_init,
  output logic [NUM_REQ-1:0]       ack,
  output logic [ID_W-1:0]          grant_id,
  output logic                     busy,
  output logic [CNT_W-1:0]         level,
  output logic                     mismatch
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   level_q, level_d;
  logic [CNT_W-1:0]   target_q, target_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic               mismatch_q, mismatch_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [ID_W-1:0]    arb_id;
  logic               arb_any;
  logic [CNT_W-1:0]   sel_target;
  logic               sel_load;
  logic [0:INPUT_SIZE-1] lvl_therm;
  logic [0:INPUT_SIZE-1] tgt_therm;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req    (req),
    .ptr    (ptr_q),
    .gnt    (arb_gnt),
    .gnt_id (arb_id),
    .any    (arb_any)
  );

  always_comb begin
    sel_target = '0;
    sel_load   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_target = req_target[i*CNT_W +: CNT_W];
        sel_load   = req_load[i];
      end
    end
    if (sel_target > CNT_W'(INPUT_SIZE)) begin
      sel_target = CNT_W'(INPUT_SIZE);
    end
    lvl_therm = INPUT_SIZE'(therm(int'(level_q)));
    tgt_therm = INPUT_SIZE'(therm(int'(target_q)));
  end

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    target_d   = target_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    mismatch_d = mismatch_q;
    unique case (state_q)
      S_INIT: begin
        state_d = S_IDLE;
      end
      S_IDLE: begin
        if (reg_out != lvl_therm) begin
          mismatch_d = 1'b1;
        end
        if (arb_any) begin
          target_d   = sel_target;
          grant_id_d = arb_id;
          state_d    = sel_load ? S_LOAD : S_STEP;
        end
      end
      S_STEP: begin
        if (level_q < target_q) begin
          level_d = level_q + 1'b1;
        end else if (level_q > target_q) begin
          level_d = level_q - 1'b1;
        end else begin
          state_d = S_ACK;
        end
      end
      S_LOAD: begin
        level_d = target_q;
        state_d = S_ACK;
      end
      S_ACK: begin
        ptr_d   = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_INIT;
      level_q    <= '0;
      target_q   <= '0;
      ptr_q      <= '0;
      grant_id_q <= '0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      target_q   <= target_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      mismatch_q <= mismatch_d;
    end
  end

  // Register controls are decoded from state so they are glitch-free and
  // mutually exclusive by construction.
  always_comb begin
    reg_rst  = (state_q == S_INIT) || (state_q == S_LOAD);
    reg_init = (state_q == S_LOAD) ? tgt_therm : '0;
    reg_inc  = (state_q == S_STEP) && (level_q < target_q);
    reg_dec  = (state_q == S_STEP) && (level_q > target_q);
    ack      = (state_q == S_ACK) ? (NUM_REQ'(1) << grant_id_q) : '0;
    busy     = (state_q != S_IDLE);
  end

  assign grant_id = grant_id_q;
  assign level    = level_q;
  assign mismatch = mismatch_q;

endmodule

// File: tb/tb_ffsr_pulse_sched.sv
// Randomized and directed bench for ffsr_pulse_sched against a transaction-level model.
module tb_ffsr_pulse_sched;

  localparam int IS = 8;
  localparam int NR = 4;
  localparam int CW = 4;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*CW-1:0]  req_target;
  logic [NR-1:0]     req_load;
  logic [0:IS-1]     reg_out;
  logic              reg_rst, reg_inc, reg_dec;
  logic [0:IS-1]     reg_init;
  logic [NR-1:0]     ack;
  logic [IW-1:0]     grant_id;
  logic              busy;
  logic [CW-1:0]     level;
  logic              mismatch;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int m_ptr = 0;
  int m_lvl = 0;
  int tgt[NR];
  int ld[NR];

  // plant: the controlled thermometer register, deliberately not at zero
  int plant_lvl = 3;
  logic [0:IS-1] flip_mask = '0;

  always #5 clk = ~clk;

  ffsr_pulse_sched #(.INPUT_SIZE(IS), .NUM_REQ(NR)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_target (req_target),
    .req_load   (req_load),
    .reg_out    (reg_out),
    .reg_rst    (reg_rst),
    .reg_inc    (reg_inc),
    .reg_dec    (reg_dec),
    .reg_init   (reg_init),
    .ack        (ack),
    .grant_id   (grant_id),
    .busy       (busy),
    .level      (level),
    .mismatch   (mismatch)
  );

  function automatic logic [0:IS-1] tb_therm(input int v);
    logic [0:IS-1] t;
    for (int i = 0; i < IS; i++) t[i] = (i >= IS - v);
    return t;
  endfunction

  always @(posedge clk) begin
    if (reg_rst) plant_lvl <= $countones(reg_init);
    else if (reg_inc && plant_lvl < IS) plant_lvl <= plant_lvl + 1;
    else if (reg_dec && plant_lvl > 0) plant_lvl <= plant_lvl - 1;
  end

  assign reg_out = tb_therm(plant_lvl) ^ flip_mask;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    #1;
    chk("rst_reg_rst", int'(reg_rst), 1);
    chk("rst_reg_init", int'(reg_init), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_ack", int'(ack), 0);
    chk("rst_cmds", int'(reg_inc) + int'(reg_dec), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_gid", int'(grant_id), 0);
    chk("rst_mismatch", int'(mismatch), 0);
    @(negedge clk);
    rst = 1'b1;
    m_ptr = 0;
    m_lvl = 0;
    #1;
    chk("init_reg_rst", int'(reg_rst), 1);
    chk("init_reg_init", int'(reg_init), 0);
    @(negedge clk);
    chk("idle_busy0", int'(busy), 0);
    chk("idle_reg_rst0", int'(reg_rst), 0);
    chk("idle_level0", int'(level), 0);
    chk("idle_mismatch0", int'(mismatch), 0);
  endtask

  // Entered and left at a negedge in IDLE; serves every requester in mask.
  task automatic serve_all(input logic [NR-1:0] mask);
    logic [NR-1:0] pend;
    int w, t, d, exp_lat, n, incs, decs, rsts, multi, init_seen;
    bit got;
    pend = mask;
    for (int i = 0; i < NR; i++) begin
      req_target[i*CW +: CW] = CW'(tgt[i]);
      req_load[i] = ld[i][0];
    end
    req = pend;
    while (pend != 0) begin
      chk("idle_busy", int'(busy), 0);
      w = -1;
      for (int k = 0; k < NR; k++) begin
        if (w < 0 && pend[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
      end
      t = (tgt[w] > IS) ? IS : tgt[w];
      d = (t > m_lvl) ? t - m_lvl : m_lvl - t;
      exp_lat = ld[w] ? 2 : d + 2;
      n = 0; incs = 0; decs = 0; rsts = 0; multi = 0; init_seen = 0; got = 0;
      while (!got && n < 40) begin
        @(negedge clk);
        n++;
        incs += int'(reg_inc);
        decs += int'(reg_dec);
        rsts += int'(reg_rst);
        if (int'(reg_inc) + int'(reg_dec) + int'(reg_rst) > 1) multi = 1;
        if (reg_rst) init_seen = int'(reg_init);
        if (ack != 0) got = 1;
      end
      chk("ack_latency", n, exp_lat);
      chk("ack_vector", int'(ack), 1 << w);
      chk("grant_id", int'(grant_id), w);
      chk("cmd_exclusive", multi, 0);
      chk("inc_count", incs, (!ld[w] && t > m_lvl) ? d : 0);
      chk("dec_count", decs, (!ld[w] && t < m_lvl) ? d : 0);
      chk("rst_count", rsts, ld[w] ? 1 : 0);
      if (ld[w]) chk("load_init", init_seen, int'(tb_therm(t)));
      pend[w] = 1'b0;
      req = pend;
      m_ptr = (w + 1) % NR;
      m_lvl = t;
      @(negedge clk);
      chk("level", int'(level), m_lvl);
      chk("no_mismatch", int'(mismatch), 0);
    end
  endtask

  initial begin
    rst = 1'b0;
    req = '0;
    req_target = '0;
    req_load = '0;
    repeat (2) @(negedge clk);
    do_reset();

    // step up then down
    tgt[0] = 5; ld[0] = 0;
    serve_all(4'b0001);
    tgt[0] = 2; ld[0] = 0;
    serve_all(4'b0001);

    // load with clamp
    tgt[2] = 15; ld[2] = 1;
    serve_all(4'b0100);

    // round robin from ptr 0, then partial, then from ptr 2
    do_reset();
    for (int i = 0; i < NR; i++) begin tgt[i] = i + 1; ld[i] = i % 2; end
    serve_all(4'b1111);
    serve_all(4'b0011);
    chk("ptr_after_pair", m_ptr, 2);
    serve_all(4'b1111);

    // randomized traffic
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < NR; i++) begin
        tgt[i] = $urandom_range(0, 15);
        ld[i] = $urandom_range(0, 1);
      end
      serve_all(NR'($urandom_range(1, 15)));
    end

    // reset in the middle of a 6-step request
    do_reset();
    tgt[0] = 6; ld[0] = 0;
    req_target[0 +: CW] = CW'(6);
    req_load[0] = 1'b0;
    req = 4'b0001;
    repeat (3) @(negedge clk);
    chk("mid_level", int'(level), 2);
    chk("mid_busy", int'(busy), 1);
    do_reset();
    repeat (3) begin
      @(negedge clk);
      chk("post_abort_ack", int'(ack), 0);
    end
    serve_all(4'b0001);

    // sticky mismatch
    flip_mask = 8'h01;
    @(negedge clk);
    flip_mask = '0;
    chk("mismatch_set", int'(mismatch), 1);
    repeat (3) @(negedge clk);
    chk("mismatch_sticky", int'(mismatch), 1);
    do_reset();
    tgt[1] = 7; ld[1] = 0;
    serve_all(4'b0010);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
